// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester/multiplier/response bundle for mult_share_arbiter
//
// Purpose: groups the requester handshake, the multiplier operand/product
// path and the response/occupancy outputs of the shared-multiplier arbiter.
// Ports (signals):
//   en         grant enable
//   req_valid  per-requester operand valid
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant
//   mul_a/b    registered operands to the multiplier
//   mul_p      product returned by the multiplier
//   rsp_valid  one-hot response pulse
//   rsp_p      routed product
//   inflight   ops issued but not yet returned
// Modports: slave = arbiter side, master = requesters + multiplier side.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18,
    parameter int WIDTH_P = 36
);
    logic                         en;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*WIDTH_A-1:0]   req_a;
    logic [NUM_REQ*WIDTH_B-1:0]   req_b;
    logic [NUM_REQ-1:0]           req_ready;
    logic [WIDTH_A-1:0]           mul_a;
    logic [WIDTH_B-1:0]           mul_b;
    logic [WIDTH_P-1:0]           mul_p;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [WIDTH_P-1:0]           rsp_p;
    logic [2:0]                   inflight;

    modport slave (
        input  en, req_valid, req_a, req_b, mul_p,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_p, inflight
    );

    modport master (
        output en, req_valid, req_a, req_b, mul_p,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_p, inflight
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter and tag scheduler for one shared pipelined multiplier
//
// Purpose: grants one requester per cycle (round robin, starting after the
// last grant), registers its operands onto the multiplier inputs and follows
// the operation through a tag delay line so the product is steered back to
// its owner exactly when it leaves the multiplier.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_share_arbiter_if.slave (see interface file for signal list)
module mult_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_A      = 18,
    parameter int WIDTH_B      = 18,
    parameter int WIDTH_P      = 36,
    parameter int MULT_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_share_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT   = MULT_LATENCY;

    logic [IDX_W-1:0]   r_last_grant;
    logic [WIDTH_A-1:0] r_mul_a;
    logic [WIDTH_B-1:0] r_mul_b;
    logic [LAT:0]       r_tag_v;
    logic [IDX_W-1:0]   r_tag_id [0:LAT];

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W:0]     w_sum;
    logic               w_found;
    logic [WIDTH_A-1:0] w_sel_a;
    logic [WIDTH_B-1:0] w_sel_b;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic [2:0]         w_inflight;

    assign w_cand = bus.req_valid & {NUM_REQ{bus.en}};

    // Round-robin search: offsets 1..NUM_REQ from the last grant, so the last
    // granted requester is considered only after everyone else.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_sum = {1'b0, r_last_grant} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && w_cand[w_idx]) begin
                w_found        = 1'b1;
                w_gidx         = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = bus.req_a[i*WIDTH_A +: WIDTH_A];
                w_sel_b = bus.req_b[i*WIDTH_B +: WIDTH_B];
            end
        end
    end

    // The multiplier cannot stall, so the tag line shifts every cycle.
    // Idle cycles push zero operands and an invalid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_tag_v      <= '0;
            for (int j = 0; j <= LAT; j++) begin
                r_tag_id[j] <= '0;
            end
        end else begin
            r_tag_v <= {r_tag_v[LAT-1:0], w_found};
            for (int j = 1; j <= LAT; j++) begin
                r_tag_id[j] <= r_tag_id[j-1];
            end
            if (w_found) begin
                r_mul_a      <= w_sel_a;
                r_mul_b      <= w_sel_b;
                r_tag_id[0]  <= w_gidx;
                r_last_grant <= w_gidx;
            end else begin
                r_mul_a      <= '0;
                r_mul_b      <= '0;
                r_tag_id[0]  <= '0;
            end
        end
    end

    // Tag at the end of the line lines up with the product on mul_p.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = r_tag_v[LAT] && (r_tag_id[LAT] == IDX_W'(i));
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int j = 0; j <= LAT; j++) begin
            w_inflight = w_inflight + 3'(r_tag_v[j]);
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_p     = (|w_rsp_valid) ? bus.mul_p : '0;
    assign bus.inflight  = w_inflight;

endmodule
